// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM write path: fetch FSM states,
// skid depth and the burst/data sizes the command scheduler also uses.
package sdram_pkg;

    localparam int SDRAM_BURST_LEN  = 8;
    localparam int SDRAM_DATA_W     = 16;
    localparam int FETCH_SKID_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } fetch_state_t;

    typedef struct packed {
        fetch_state_t state;
        logic         flush_pend;
        logic [1:0]   skid_count;
        logic         inflight;
    } fetch_dbg_t;

endpackage

// File: rtl/sdram_wr_fetch_if.sv
// Signal bundle between the write-path FIFO read port, the command scheduler
// and the write data path, as seen by the fetch engine (master) and its peers.
interface sdram_wr_fetch_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int LEN_W  = 4
);
    logic              fifo_empty_i;
    logic [CNT_W-1:0]  fifo_data_num_i;
    logic              fifo_rd_en_o;
    logic [DATA_W-1:0] fifo_rd_data_i;
    logic              flush_i;
    logic              burst_req_o;
    logic [LEN_W-1:0]  burst_len_o;
    logic              burst_ack_i;
    // Beat transfer: wr_data_o/wr_last_o are meaningful only while wr_valid_o
    // is high; once raised, valid and data hold until wr_ready_i is seen high
    // on a clock edge, and that edge is the single point where the beat moves.
    logic              wr_valid_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_last_o;
    logic              wr_ready_i;
    logic              busy_o;

    modport master (
        input  fifo_empty_i, fifo_data_num_i, fifo_rd_data_i, flush_i,
        input  burst_ack_i, wr_ready_i,
        output fifo_rd_en_o, burst_req_o, burst_len_o,
        output wr_valid_o, wr_data_o, wr_last_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_num_i, fifo_rd_data_i, flush_i,
        output burst_ack_i, wr_ready_i,
        input  fifo_rd_en_o, burst_req_o, burst_len_o,
        input  wr_valid_o, wr_data_o, wr_last_o, busy_o
    );

endinterface

// File: rtl/sdram_wr_fetch_skid_buf.sv
// Three-entry skid FIFO that absorbs FIFO read latency; an empty buffer
// passes the arriving word straight through so a beat costs no extra cycle.
module fetch_skid_buf
    import sdram_pkg::*;
#(
    parameter int DATA_W = SDRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [FETCH_SKID_DEPTH];
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [1:0]        cnt;
    logic              stored;
    logic              take;
    logic              wr;
    logic              rd;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(FETCH_SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign stored    = (cnt != 2'd0);
    assign out_valid = stored || push;
    assign out_data  = stored ? mem[head] : (push ? push_data : '0);
    assign take      = out_valid && out_ready;
    // A word consumed in its arrival cycle never touches storage.
    assign wr        = push && !(!stored && take);
    assign rd        = take && stored;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= 2'd0;
            tail <= 2'd0;
            cnt  <= 2'd0;
        end else begin
            if (wr) begin
                tail <= ptr_next(tail);
            end
            if (rd) begin
                head <= ptr_next(head);
            end
            cnt <= cnt + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: rtl/sdram_wr_fetch.sv
// Drains the write-path async FIFO in SDRAM-sized bursts: requests a burst
// from the scheduler, then pops exactly the granted length into the data path.
module sdram_wr_fetch
    import sdram_pkg::*;
#(
    parameter int DATA_W    = SDRAM_DATA_W,
    parameter int CNT_W     = 8,
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int LEN_W     = $clog2(BURST_LEN) + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    sdram_wr_fetch_if.master  bus,
    output fetch_dbg_t        dbg
);

    localparam logic [CNT_W-1:0] FULL_NUM = CNT_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BURST_LEN);

    fetch_state_t      state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  sent;
    logic              inflight;
    logic              flush_pend;
    logic              burst_req;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [1:0]        skid_count;
    logic [2:0]        outstanding;
    logic              pop;
    logic              beat;
    logic              last_beat;

    // Buffered words plus the one possibly on its way must fit the skid.
    assign outstanding = {1'b0, skid_count} + {2'b0, inflight};
    assign pop         = (state == XFER) && (issued < len) && !bus.fifo_empty_i
                         && (outstanding < 3'(FETCH_SKID_DEPTH));
    assign beat        = skid_valid && bus.wr_ready_i;
    assign last_beat   = skid_valid && (sent == len - LEN_W'(1));

    fetch_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (inflight),
        .push_data (bus.fifo_rd_data_i),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (bus.wr_ready_i),
        .count     (skid_count)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            len        <= '0;
            issued     <= '0;
            sent       <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            burst_req  <= 1'b0;
        end else begin
            inflight <= pop;
            case (state)
                IDLE: begin
                    if (bus.fifo_data_num_i >= FULL_NUM) begin
                        len       <= FULL_LEN;
                        burst_req <= 1'b1;
                        state     <= REQ;
                    end else if (flush_pend && (bus.fifo_data_num_i != '0)) begin
                        len       <= LEN_W'(bus.fifo_data_num_i);
                        burst_req <= 1'b1;
                        state     <= REQ;
                    end else if (flush_pend) begin
                        flush_pend <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.burst_ack_i) begin
                        burst_req <= 1'b0;
                        issued    <= '0;
                        sent      <= '0;
                        state     <= XFER;
                        if (len < FULL_LEN) begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
                XFER: begin
                    if (pop) begin
                        issued <= issued + LEN_W'(1);
                    end
                    if (beat) begin
                        sent <= sent + LEN_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A new flush always wins over a same-cycle clear.
            if (bus.flush_i) begin
                flush_pend <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en_o = pop;
    assign bus.burst_req_o  = burst_req;
    assign bus.burst_len_o  = len;
    assign bus.wr_valid_o   = skid_valid;
    assign bus.wr_data_o    = skid_data;
    assign bus.wr_last_o    = last_beat;
    assign bus.busy_o       = (state != IDLE) || (skid_count != 2'd0);

    always_comb begin
        dbg            = '0;
        dbg.state      = state;
        dbg.flush_pend = flush_pend;
        dbg.skid_count = skid_count;
        dbg.inflight   = inflight;
    end

endmodule

// File: tb/tb_sdram_wr_fetch.sv
// Directed-plus-random bench for sdram_wr_fetch: queue-based FIFO and scheduler
// models around the DUT, scoreboard on the beat stream, timing spot checks.
module tb_sdram_wr_fetch;
    import sdram_pkg::*;

    localparam int DATA_W    = 16;
    localparam int CNT_W     = 8;
    localparam int BURST_LEN = 8;
    localparam int LEN_W     = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    fetch_dbg_t dbg;

    always #5 sys_clk = ~sys_clk;

    sdram_wr_fetch_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    sdram_wr_fetch #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .BURST_LEN (BURST_LEN),
        .LEN_W     (LEN_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .dbg     (dbg)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int rise_q[$];
    int last_q[$];

    int num_bias = 0;
    int rdy_mode = 1;
    int rdy_ph = 0;
    int ack_delay = 1;
    int req_age = 0;
    int ack_cyc = -100;
    int trickle_left = 0;
    int trickle_ph = 0;
    int want_len = BURST_LEN;
    int beat_idx = 0;
    int pops = 0;
    int bursts_done = 0;
    bit timing_chk = 1'b0;
    bit saw_req = 1'b0;
    bit saw_rd = 1'b0;
    bit req_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty_i    = (fifo_q.size() == 0);
        bus.fifo_data_num_i = CNT_W'(fifo_q.size() + num_bias);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: sample just before the edge, then update the models and
    // drive the next inputs at the following falling edge.
    task automatic cycle();
        logic rd, v, rdy, l;
        logic [DATA_W-1:0] d;
        #2;
        rd  = bus.fifo_rd_en_o;
        v   = bus.wr_valid_o;
        rdy = bus.wr_ready_i;
        l   = bus.wr_last_o;
        d   = bus.wr_data_o;
        if (bus.burst_req_o) begin
            saw_req = 1'b1;
            chk("burst_len", 32'(bus.burst_len_o), want_len);
            if (!req_prev) rise_q.push_back(cyc);
        end
        req_prev = bus.burst_req_o;
        if (rd) begin
            saw_rd = 1'b1;
            chk("pop_while_empty", 32'(fifo_q.size() == 0), 0);
            pops++;
            chk("outstanding_le3", 32'((pops - beat_idx) <= 3), 1);
            chk("pop_le_len", 32'(pops <= want_len), 1);
            if (timing_chk && pops == 1) chk("first_pop_cyc", cyc, ack_cyc + 1);
        end
        if (v && rdy) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat_data", d, exp_q.pop_front());
            chk("beat_last", 32'(l), 32'(beat_idx == want_len - 1));
            if (timing_chk && beat_idx == 0) chk("first_beat_cyc", cyc, ack_cyc + 2);
            if (l) begin
                if (timing_chk) chk("last_beat_cyc", cyc, ack_cyc + 1 + want_len);
                chk("pop_total", pops, want_len);
                last_q.push_back(cyc);
                bursts_done++;
                beat_idx = 0;
                pops = 0;
            end else begin
                beat_idx++;
            end
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        if (rd && fifo_q.size() > 0) bus.fifo_rd_data_i = fifo_q.pop_front();
        if (trickle_left > 0) begin
            trickle_ph++;
            if (trickle_ph == 3) begin
                trickle_ph = 0;
                push_word(DATA_W'($urandom));
                trickle_left--;
            end
        end
        case (rdy_mode)
            0: bus.wr_ready_i = 1'b0;
            1: bus.wr_ready_i = 1'b1;
            2: begin bus.wr_ready_i = (rdy_ph % 3 == 0); rdy_ph++; end
            default: bus.wr_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (bus.burst_req_o && !bus.burst_ack_i) begin
            if (req_age >= ack_delay) begin
                bus.burst_ack_i = 1'b1;
                ack_cyc = cyc;
                req_age = 0;
            end else begin
                req_age++;
            end
        end else begin
            bus.burst_ack_i = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic run_bursts(input int n, input int budget);
        int start;
        int k;
        start = bursts_done;
        k = 0;
        while (bursts_done < start + n && k < budget) begin
            cycle();
            k++;
        end
        chk("burst_complete", bursts_done - start, n);
    endtask

    task automatic do_reset();
        rdy_mode = 0;
        bus.wr_ready_i = 1'b0;
        bus.burst_ack_i = 1'b0;
        sys_rst = 1'b1;
        cycle();
        sys_rst = 1'b0;
        bus.burst_ack_i = 1'b0;
        req_age = 0;
        beat_idx = 0;
        pops = 0;
        req_prev = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en_o), 0);
        chk({tag, "_req"}, 32'(bus.burst_req_o), 0);
        chk({tag, "_len"}, 32'(bus.burst_len_o), 0);
        chk({tag, "_valid"}, 32'(bus.wr_valid_o), 0);
        chk({tag, "_data"}, 32'(bus.wr_data_o), 0);
        chk({tag, "_last"}, 32'(bus.wr_last_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    endtask

    initial begin
        int t0;
        int remain;
        bus.fifo_rd_data_i = '0;
        bus.flush_i = 1'b0;
        bus.burst_ack_i = 1'b0;
        bus.wr_ready_i = 1'b0;
        drive_fifo();
        @(negedge sys_clk);
        repeat (3) cycle();
        sys_rst = 1'b0;
        check_quiet("reset");
        chk("reset_flush_pend", 32'(dbg.flush_pend), 0);

        // 1: seven words and no flush never start a burst
        rdy_mode = 1;
        for (int i = 0; i < 7; i++) push_word(DATA_W'($urandom));
        saw_req = 1'b0;
        saw_rd = 1'b0;
        repeat (100) cycle();
        chk("t1_no_req", 32'(saw_req), 0);
        chk("t1_no_rd", 32'(saw_rd), 0);
        fifo_q.delete();
        exp_q.delete();
        drive_fifo();
        do_reset();

        // 2: two full bursts back to back, ready always high, ack one cycle late
        rdy_mode = 1;
        timing_chk = 1'b1;
        ack_delay = 1;
        want_len = 8;
        rise_q.delete();
        last_q.delete();
        t0 = cyc;
        for (int i = 1; i <= 16; i++) push_word(DATA_W'(i));
        run_bursts(2, 200);
        chk("t2_req1_cyc", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 1);
        chk("t2_req2_cyc", rise_q.size() > 1 ? rise_q[1] : -1,
            last_q.size() > 0 ? last_q[0] + 2 : -1);
        cycle();
        chk("t2_idle_busy", 32'(bus.busy_o), 0);
        chk("t2_all_beats", exp_q.size(), 0);
        timing_chk = 1'b0;

        // 3: flush drains a partial burst; a flush with nothing buffered is dropped
        for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom));
        want_len = 3;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        run_bursts(1, 100);
        cycle();
        chk("t3_flush_cleared", 32'(dbg.flush_pend), 0);
        saw_req = 1'b0;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        repeat (20) cycle();
        chk("t3_empty_flush_no_req", 32'(saw_req), 0);
        chk("t3_empty_flush_cleared", 32'(dbg.flush_pend), 0);

        // 4: stalling data path, ready pattern 1,0,0
        rdy_mode = 2;
        rdy_ph = 0;
        want_len = 8;
        for (int i = 0; i < 8; i++) push_word(DATA_W'($urandom));
        run_bursts(1, 200);
        chk("t4_all_beats", exp_q.size(), 0);

        // 5: optimistic count with a slow writer forces the pop path through empty
        rdy_mode = 1;
        want_len = 8;
        for (int i = 0; i < 2; i++) push_word(DATA_W'($urandom));
        num_bias = 6;
        trickle_left = 6;
        trickle_ph = 0;
        drive_fifo();
        saw_req = 1'b0;
        for (int k = 0; k < 20 && !saw_req; k++) cycle();
        chk("t5_req_seen", 32'(saw_req), 1);
        num_bias = 0;
        drive_fifo();
        run_bursts(1, 200);
        chk("t5_all_beats", exp_q.size(), 0);
        chk("t5_fifo_drained", fifo_q.size(), 0);

        // 6: reset in the middle of a burst
        rdy_mode = 1;
        want_len = 8;
        for (int i = 0; i < 8; i++) push_word(DATA_W'($urandom));
        for (int k = 0; k < 50 && beat_idx < 4; k++) cycle();
        chk("t6_reached_beat4", beat_idx, 4);
        do_reset();
        check_quiet("t6_after_rst");
        exp_q = fifo_q;
        remain = fifo_q.size();
        rdy_mode = 1;
        saw_req = 1'b0;
        repeat (40) cycle();
        chk("t6_no_req_partial", 32'(saw_req), 0);
        for (int i = remain; i < 8; i++) push_word(DATA_W'($urandom));
        run_bursts(1, 100);
        chk("t6_all_beats", exp_q.size(), 0);

        // 7: random ready and random grant latency
        rdy_mode = 3;
        want_len = 8;
        for (int b = 0; b < 4; b++) begin
            ack_delay = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) push_word(DATA_W'($urandom));
            run_bursts(1, 300);
        end
        chk("t7_all_beats", exp_q.size(), 0);
        rdy_mode = 1;
        repeat (3) cycle();
        chk("end_idle_busy", 32'(bus.busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
